// File: rtl/rv32i_alu_mc.sv
`timescale 1ns/1ps
// rv32i_alu_mc: execute-stage ALU with single-cycle base ops and an iterative
// shift-add multiplier / restoring divider that share one accumulator datapath.
//
// Handshake: i_ce is "valid" from decode. The ALU is "ready" when it is idle
// and neither i_stall nor i_flush is asserted. An op is taken on the edge where
// valid and ready are both high. While o_stall_from_alu is high the op is not
// consumed and decode must keep presenting it. o_ce marks exactly one result.
// While i_stall is high, o_ce/o_y/o_rd_addr hold their values.
module rv32i_alu_mc #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_ce,
   input  logic [3:0]      i_op,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   input  logic [RD_W-1:0] i_rd_addr,
   input  logic            i_stall,
   input  logic            i_flush,
   output logic            o_ce,
   output logic [XLEN-1:0] o_y,
   output logic [RD_W-1:0] o_rd_addr,
   output logic            o_stall_from_alu,
   output logic [1:0]      o_dbg_state
);

   localparam int SH_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_SLT   = 4'd2;
   localparam logic [3:0] OP_SLTU  = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_OR    = 4'd5;
   localparam logic [3:0] OP_AND   = 4'd6;
   localparam logic [3:0] OP_SLL   = 4'd7;
   localparam logic [3:0] OP_SRL   = 4'd8;
   localparam logic [3:0] OP_SRA   = 4'd9;
   localparam logic [3:0] OP_MUL   = 4'd10;
   localparam logic [3:0] OP_MULHU = 4'd11;
   localparam logic [3:0] OP_DIV   = 4'd12;
   localparam logic [3:0] OP_DIVU  = 4'd13;
   localparam logic [3:0] OP_REM   = 4'd14;
   localparam logic [3:0] OP_REMU  = 4'd15;

   // Debug encoding visible on o_dbg_state: 0 idle, 1 busy, 2 done.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state;
   logic [SH_W-1:0] cnt;
   logic [3:0]      op_q;
   logic [RD_W-1:0] rd_q;
   logic [XLEN-1:0] acc_hi;    // multiply: upper product; divide: partial remainder
   logic [XLEN-1:0] acc_lo;    // multiply: multiplier/low product; divide: quotient
   logic [XLEN-1:0] opb;       // multiplicand or divisor magnitude
   logic            neg_q;
   logic            neg_r;

   logic [SH_W-1:0] shamt;
   logic            is_div_op;
   logic            is_sdiv;
   logic            div_by_zero;
   logic            div_ovf;
   logic            is_iter;
   logic            accept;
   logic [XLEN-1:0] quick_res;
   logic [XLEN-1:0] abs1;
   logic [XLEN-1:0] abs2;

   logic            op_mul;
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   rem_shift;
   logic [XLEN:0]   rem_diff;
   logic [XLEN-1:0] hi_n;
   logic [XLEN-1:0] lo_n;
   logic [XLEN-1:0] fin_busy;
   logic [XLEN-1:0] fin_done;

   assign o_stall_from_alu = (state != S_IDLE);
   assign o_dbg_state      = state;
   assign shamt            = i_rs2[SH_W-1:0];

   // Turns the raw accumulator contents into the architectural result.
   function automatic logic [XLEN-1:0] pick_result(input logic [3:0]      op,
                                                   input logic [XLEN-1:0] hi,
                                                   input logic [XLEN-1:0] lo,
                                                   input logic            nq,
                                                   input logic            nr);
      logic [XLEN-1:0] r;
      case (op)
         OP_MUL:          r = lo;
         OP_MULHU:        r = hi;
         OP_DIV, OP_DIVU: r = nq ? -lo : lo;
         default:         r = nr ? -hi : hi;
      endcase
      return r;
   endfunction

   // Decode: acceptance, divide special cases and operand magnitudes.
   always_comb begin
      is_div_op   = (i_op == OP_DIV) || (i_op == OP_DIVU) || (i_op == OP_REM) || (i_op == OP_REMU);
      is_sdiv     = (i_op == OP_DIV) || (i_op == OP_REM);
      div_by_zero = is_div_op && (i_rs2 == '0);
      div_ovf     = is_sdiv && (i_rs1 == MIN_VAL) && (i_rs2 == '1);
      is_iter     = (i_op >= OP_MUL) && !div_by_zero && !div_ovf;
      accept      = i_ce && (state == S_IDLE) && !i_stall && !i_flush;
      abs1        = (is_sdiv && i_rs1[XLEN-1]) ? -i_rs1 : i_rs1;
      abs2        = (is_sdiv && i_rs2[XLEN-1]) ? -i_rs2 : i_rs2;
   end

   // Single-cycle results, including the divide corner cases that skip iteration.
   always_comb begin
      quick_res = '0;
      case (i_op)
         OP_ADD:          quick_res = i_rs1 + i_rs2;
         OP_SUB:          quick_res = i_rs1 - i_rs2;
         OP_SLT:          quick_res = {{(XLEN-1){1'b0}}, ($signed(i_rs1) < $signed(i_rs2))};
         OP_SLTU:         quick_res = {{(XLEN-1){1'b0}}, (i_rs1 < i_rs2)};
         OP_XOR:          quick_res = i_rs1 ^ i_rs2;
         OP_OR:           quick_res = i_rs1 | i_rs2;
         OP_AND:          quick_res = i_rs1 & i_rs2;
         OP_SLL:          quick_res = i_rs1 << shamt;
         OP_SRL:          quick_res = i_rs1 >> shamt;
         OP_SRA:          quick_res = $unsigned($signed(i_rs1) >>> shamt);
         OP_DIV, OP_DIVU: quick_res = div_by_zero ? '1 : MIN_VAL;
         OP_REM, OP_REMU: quick_res = div_by_zero ? i_rs1 : '0;
         default:         quick_res = '0;
      endcase
   end

   // One iteration of the shared datapath: shift-add multiply or restoring divide.
   always_comb begin
      op_mul    = (op_q == OP_MUL) || (op_q == OP_MULHU);
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
      rem_shift = {acc_hi, acc_lo[XLEN-1]};
      rem_diff  = rem_shift - {1'b0, opb};
      if (op_mul) begin
         hi_n = mul_sum[XLEN:1];
         lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};
      end else if (!rem_diff[XLEN]) begin
         hi_n = rem_diff[XLEN-1:0];
         lo_n = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
         hi_n = rem_shift[XLEN-1:0];
         lo_n = {acc_lo[XLEN-2:0], 1'b0};
      end
      fin_busy = pick_result(op_q, hi_n, lo_n, neg_q, neg_r);
      fin_done = pick_result(op_q, acc_hi, acc_lo, neg_q, neg_r);
   end

   // Control FSM with registered result outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         op_q      <= '0;
         rd_q      <= '0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         opb       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         o_ce      <= 1'b0;
         o_y       <= '0;
         o_rd_addr <= '0;
      end else if (i_flush) begin
         state <= S_IDLE;
         cnt   <= '0;
         o_ce  <= 1'b0;
      end else begin
         // Unstalled edges clear the pulse unless a new result is loaded below.
         if (!i_stall) o_ce <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (is_iter) begin
                     state  <= S_BUSY;
                     cnt    <= SH_W'(XLEN - 1);
                     op_q   <= i_op;
                     rd_q   <= i_rd_addr;
                     acc_hi <= '0;
                     acc_lo <= abs1;
                     opb    <= abs2;
                     neg_q  <= is_sdiv && (i_rs1[XLEN-1] ^ i_rs2[XLEN-1]);
                     neg_r  <= is_sdiv && i_rs1[XLEN-1];
                  end else begin
                     o_ce      <= 1'b1;
                     o_y       <= quick_res;
                     o_rd_addr <= i_rd_addr;
                  end
               end
            end
            S_BUSY: begin
               acc_hi <= hi_n;
               acc_lo <= lo_n;
               if (cnt == '0) begin
                  if (!i_stall) begin
                     o_ce      <= 1'b1;
                     o_y       <= fin_busy;
                     o_rd_addr <= rd_q;
                     state     <= S_IDLE;
                  end else begin
                     state <= S_DONE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_DONE: begin
               if (!i_stall) begin
                  o_ce      <= 1'b1;
                  o_y       <= fin_done;
                  o_rd_addr <= rd_q;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_alu_mc.sv
`timescale 1ns/1ps
// Self-checking bench for rv32i_alu_mc (XLEN=32): directed corner cases plus
// randomized ops against a plain-arithmetic reference model.
module tb_rv32i_alu_mc;

   localparam logic [31:0] MIN32    = 32'h8000_0000;
   localparam logic [1:0]  DBG_DONE = 2'd2;

   logic        clk;
   logic        i_rst;
   logic        i_ce;
   logic [3:0]  i_op;
   logic [31:0] i_rs1;
   logic [31:0] i_rs2;
   logic [4:0]  i_rd_addr;
   logic        i_stall;
   logic        i_flush;
   logic        o_ce;
   logic [31:0] o_y;
   logic [4:0]  o_rd_addr;
   logic        o_stall_from_alu;
   logic [1:0]  o_dbg_state;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   rv32i_alu_mc #(.XLEN(32), .RD_W(5)) dut (
      .i_clk            (clk),
      .i_rst            (i_rst),
      .i_ce             (i_ce),
      .i_op             (i_op),
      .i_rs1            (i_rs1),
      .i_rs2            (i_rs2),
      .i_rd_addr        (i_rd_addr),
      .i_stall          (i_stall),
      .i_flush          (i_flush),
      .o_ce             (o_ce),
      .o_y              (o_y),
      .o_rd_addr        (o_rd_addr),
      .o_stall_from_alu (o_stall_from_alu),
      .o_dbg_state      (o_dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model: result from arithmetic rules
   function automatic logic [31:0] model_y(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic [63:0]        p;
      logic [31:0]        r;
      sa = a;
      sb = b;
      p  = {32'h0, a} * {32'h0, b};
      case (op)
         4'd0:  r = a + b;
         4'd1:  r = a - b;
         4'd2:  r = (sa < sb) ? 32'd1 : 32'd0;
         4'd3:  r = (a < b) ? 32'd1 : 32'd0;
         4'd4:  r = a ^ b;
         4'd5:  r = a | b;
         4'd6:  r = a & b;
         4'd7:  r = a << b[4:0];
         4'd8:  r = a >> b[4:0];
         4'd9:  r = $unsigned(sa >>> b[4:0]);
         4'd10: r = p[31:0];
         4'd11: r = p[63:32];
         4'd12: r = (b == 0) ? 32'hFFFF_FFFF : ((a == MIN32 && b == 32'hFFFF_FFFF) ? MIN32 : $unsigned(sa / sb));
         4'd13: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'd14: r = (b == 0) ? a : ((a == MIN32 && b == 32'hFFFF_FFFF) ? 32'd0 : $unsigned(sa % sb));
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // reference model: cycles from accept to o_ce
   function automatic int model_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op < 4'd10) return 1;
      if (op >= 4'd12 && b == 0) return 1;
      if ((op == 4'd12 || op == 4'd14) && a == MIN32 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] rand_operand();
      logic [31:0] v;
      case ($urandom_range(0, 6))
         0: v = 32'h0;
         1: v = MIN32;
         2: v = 32'hFFFF_FFFF;
         3: v = $urandom_range(0, 20);
         4: v = -$urandom_range(1, 20);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // driver: present one op (ALU idle), wait for its result pulse
   task automatic issue_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, output logic got, output logic [31:0] y,
                           output logic [4:0] rd, output int lat, output int busy);
      i_ce      = 1'b1;
      i_op      = op;
      i_rs1     = a;
      i_rs2     = b;
      i_rd_addr = tag;
      @(posedge clk); #1;
      i_ce  = 1'b0;
      i_rs1 = $urandom;
      i_rs2 = $urandom;
      lat   = 1;
      busy  = 0;
      while (o_ce !== 1'b1 && lat < 100) begin
         if (o_stall_from_alu === 1'b1) busy++;
         @(posedge clk); #1;
         lat++;
      end
      got = o_ce;
      y   = o_y;
      rd  = o_rd_addr;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      i_ce  = 1'b1;
      i_op  = 4'd0;
      i_rs1 = $urandom;
      i_rs2 = $urandom;
      repeat (3) @(posedge clk);
      #1;
      total++; if (o_ce !== 1'b0) begin bad++; $display("FAIL reset_ce: got=%b want=0", o_ce); end
      total++; if (o_y !== 32'h0) begin bad++; $display("FAIL reset_y: got=%h want=0", o_y); end
      total++; if (o_rd_addr !== 5'h0) begin bad++; $display("FAIL reset_rd: got=%h want=0", o_rd_addr); end
      total++; if (o_stall_from_alu !== 1'b0) begin bad++; $display("FAIL reset_stall: got=%b want=0", o_stall_from_alu); end
      i_rst = 1'b0;
      i_ce  = 1'b0;
      @(posedge clk); #1;
      total++; if (o_dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got=%0d want=0", o_dbg_state); end
   endtask

   task automatic test_add();
      logic got; logic [31:0] y; logic [31:0] exp; logic [4:0] rd; int lat; int busy;
      exp_q.push_back(model_y(4'd0, 32'd5, 32'd7));
      issue_op(4'd0, 32'd5, 32'd7, 5'd3, got, y, rd, lat, busy);
      exp = exp_q.pop_front();
      total++; if (!got || y !== exp) begin bad++; $display("FAIL add_y: got=%h ce=%b want=%h", y, got, exp); end
      total++; if (rd !== 5'd3) begin bad++; $display("FAIL add_rd: got=%0d want=3", rd); end
      total++; if (lat != 1) begin bad++; $display("FAIL add_lat: got=%0d want=1", lat); end
      @(posedge clk); #1;
      total++; if (o_ce !== 1'b0) begin bad++; $display("FAIL add_pulse: got=%b want=0", o_ce); end
   endtask

   task automatic test_base_random();
      logic got; logic [31:0] y; logic [31:0] a; logic [31:0] b; logic [31:0] exp;
      logic [4:0] rd; logic [4:0] tag; logic [3:0] op; int lat; int busy;
      for (int n = 0; n < 40; n++) begin
         op  = 4'($urandom_range(0, 9));
         a   = rand_operand();
         b   = rand_operand();
         tag = 5'($urandom);
         exp_q.push_back(model_y(op, a, b));
         issue_op(op, a, b, tag, got, y, rd, lat, busy);
         exp = exp_q.pop_front();
         total++; if (!got || y !== exp || rd !== tag) begin
            bad++; $display("FAIL base op=%0d a=%h b=%h: got=%h rd=%0d want=%h rd=%0d", op, a, b, y, rd, exp, tag);
         end
         total++; if (lat != 1) begin bad++; $display("FAIL base_lat op=%0d: got=%0d want=1", op, lat); end
      end
   endtask

   // directed table covers divide, divide corner cases and multiply
   task automatic test_directed_iter();
      logic [3:0]  ops [12] = '{4'd13, 4'd15, 4'd12, 4'd14, 4'd12, 4'd14, 4'd12, 4'd14, 4'd10, 4'd11, 4'd13, 4'd15};
      logic [31:0] as  [12] = '{32'd100, 32'd100, -32'd100, -32'd100, 32'h10, 32'h10, MIN32, MIN32,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234};
      logic [31:0] bs  [12] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
      logic [31:0] want[12] = '{32'd14, 32'd2, -32'd14, -32'd2, 32'hFFFF_FFFF, 32'h10, MIN32, 32'd0,
                                32'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h1234};
      int          lats[12] = '{33, 33, 33, 33, 1, 1, 1, 1, 33, 33, 1, 1};
      logic got; logic [31:0] y; logic [31:0] exp; logic [4:0] rd; int lat; int busy;
      for (int n = 0; n < 12; n++) begin
         exp_q.push_back(want[n]);
         issue_op(ops[n], as[n], bs[n], 5'(n + 1), got, y, rd, lat, busy);
         exp = exp_q.pop_front();
         total++; if (!got || y !== exp || rd !== 5'(n + 1)) begin
            bad++; $display("FAIL dir%0d op=%0d: got=%h rd=%0d want=%h", n, ops[n], y, rd, exp);
         end
         total++; if (lat != lats[n] || busy != lats[n] - 1) begin
            bad++; $display("FAIL dir%0d_lat: got lat=%0d busy=%0d want lat=%0d", n, lat, busy, lats[n]);
         end
      end
   endtask

   task automatic test_random_mix();
      logic got; logic [31:0] y; logic [31:0] a; logic [31:0] b; logic [31:0] exp;
      logic [4:0] rd; logic [4:0] tag; logic [3:0] op; int lat; int busy; int elat;
      for (int n = 0; n < 40; n++) begin
         op   = (n % 2 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 15));
         a    = rand_operand();
         b    = rand_operand();
         tag  = 5'($urandom);
         elat = model_lat(op, a, b);
         exp_q.push_back(model_y(op, a, b));
         issue_op(op, a, b, tag, got, y, rd, lat, busy);
         exp = exp_q.pop_front();
         total++; if (!got || y !== exp || rd !== tag) begin
            bad++; $display("FAIL mix op=%0d a=%h b=%h: got=%h rd=%0d want=%h rd=%0d", op, a, b, y, rd, exp, tag);
         end
         total++; if (lat != elat || busy != elat - 1) begin
            bad++; $display("FAIL mix_lat op=%0d: got lat=%0d busy=%0d want lat=%0d", op, lat, busy, elat);
         end
      end
   endtask

   // op held by decode while busy is ignored, then taken in the result cycle
   task automatic test_back_to_back();
      int cyc;
      exp_q.push_back(model_y(4'd13, 32'd100, 32'd7));
      exp_q.push_back(model_y(4'd0, 32'd1, 32'd2));
      i_ce = 1'b1; i_op = 4'd13; i_rs1 = 32'd100; i_rs2 = 32'd7; i_rd_addr = 5'd9;
      @(posedge clk); #1;
      i_op = 4'd0; i_rs1 = 32'd1; i_rs2 = 32'd2; i_rd_addr = 5'd4;
      cyc = 1;
      while (o_ce !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      total++; if (cyc != 33 || o_y !== exp_q[0] || o_rd_addr !== 5'd9) begin
         bad++; $display("FAIL b2b_first: cyc=%0d y=%h rd=%0d want cyc=33 y=%h rd=9", cyc, o_y, o_rd_addr, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(posedge clk); #1;
      i_ce = 1'b0;
      total++; if (o_ce !== 1'b1 || o_y !== exp_q[0] || o_rd_addr !== 5'd4) begin
         bad++; $display("FAIL b2b_second: ce=%b y=%h rd=%0d want ce=1 y=%h rd=4", o_ce, o_y, o_rd_addr, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(posedge clk); #1;
      total++; if (o_ce !== 1'b0) begin bad++; $display("FAIL b2b_pulse: got=%b want=0", o_ce); end
   endtask

   // downstream stall across the end of a divide, then a stall on the result itself
   task automatic test_stall();
      int early;
      logic [31:0] exp;
      exp = model_y(4'd13, 32'd1000, 32'd7);
      i_ce = 1'b1; i_op = 4'd13; i_rs1 = 32'd1000; i_rs2 = 32'd7; i_rd_addr = 5'd11;
      @(posedge clk); #1;
      i_ce  = 1'b0;
      early = 0;
      for (int cyc = 1; cyc <= 47; cyc++) begin
         if (cyc <= 41 && o_ce === 1'b1) early++;
         if (cyc == 35) begin
            total++; if (o_dbg_state !== DBG_DONE || o_stall_from_alu !== 1'b1) begin
               bad++; $display("FAIL stall_done: state=%0d busy=%b want state=2 busy=1", o_dbg_state, o_stall_from_alu);
            end
         end
         if (cyc == 42) begin
            total++; if (o_ce !== 1'b1 || o_y !== exp || o_rd_addr !== 5'd11) begin
               bad++; $display("FAIL stall_release: ce=%b y=%h rd=%0d want ce=1 y=%h rd=11", o_ce, o_y, o_rd_addr, exp);
            end
         end
         if (cyc == 45) begin
            total++; if (o_ce !== 1'b1 || o_y !== exp) begin
               bad++; $display("FAIL stall_hold: ce=%b y=%h want ce=1 y=%h", o_ce, o_y, exp);
            end
         end
         if (cyc == 46) begin
            total++; if (o_ce !== 1'b0) begin bad++; $display("FAIL stall_pulse_end: got=%b want=0", o_ce); end
         end
         i_stall = ((cyc >= 30 && cyc <= 40) || (cyc >= 42 && cyc <= 44));
         @(posedge clk); #1;
      end
      i_stall = 1'b0;
      total++; if (early != 0) begin bad++; $display("FAIL stall_early_ce: got=%0d pulses want=0", early); end
   endtask

   // abort a divide mid-flight with flush (use_rst=0) or reset (use_rst=1)
   task automatic test_abort(input logic use_rst);
      int ces;
      logic got; logic [31:0] y; logic [31:0] exp; logic [4:0] rd; int lat; int busy;
      exp_q.push_back(model_y(4'd0, 32'd3, 32'd4));
      issue_op(4'd0, 32'd3, 32'd4, 5'd5, got, y, rd, lat, busy);
      exp = exp_q.pop_front();
      total++; if (!got || y !== exp) begin bad++; $display("FAIL abort_pre: got=%h want=%h", y, exp); end
      i_ce = 1'b1; i_op = 4'd12; i_rs1 = -32'd1000; i_rs2 = 32'd3; i_rd_addr = 5'd7;
      @(posedge clk); #1;
      i_ce = 1'b0;
      ces  = 0;
      for (int cyc = 1; cyc <= 50; cyc++) begin
         if (cyc == 11) begin
            total++; if (o_stall_from_alu !== 1'b0 || o_ce !== 1'b0) begin
               bad++; $display("FAIL abort_idle rst=%b: busy=%b ce=%b want 0 0", use_rst, o_stall_from_alu, o_ce);
            end
            if (use_rst) begin
               total++; if (o_y !== 32'h0 || o_rd_addr !== 5'h0) begin
                  bad++; $display("FAIL abort_zero: y=%h rd=%0d want 0 0", o_y, o_rd_addr);
               end
            end
            i_rst = 1'b0; i_flush = 1'b0; i_ce = 1'b0;
         end
         if (o_ce === 1'b1) ces++;
         if (cyc == 10) begin
            if (use_rst) i_rst = 1'b1; else i_flush = 1'b1;
            i_ce = 1'b1; i_op = 4'd0; i_rs1 = 32'd5; i_rs2 = 32'd5; i_rd_addr = 5'd2;
         end
         @(posedge clk); #1;
      end
      total++; if (ces != 0) begin bad++; $display("FAIL abort_no_ce rst=%b: got=%0d pulses want=0", use_rst, ces); end
      exp_q.push_back(model_y(4'd0, 32'd1, 32'd1));
      issue_op(4'd0, 32'd1, 32'd1, 5'd6, got, y, rd, lat, busy);
      exp = exp_q.pop_front();
      total++; if (!got || y !== exp || rd !== 5'd6 || lat != 1) begin
         bad++; $display("FAIL abort_after rst=%b: got=%h rd=%0d lat=%0d want=%h rd=6 lat=1", use_rst, y, rd, lat, exp);
      end
   endtask

   initial begin
      i_rst = 1'b1; i_ce = 1'b0; i_op = 4'd0; i_rs1 = '0; i_rs2 = '0;
      i_rd_addr = '0; i_stall = 1'b0; i_flush = 1'b0;
      test_reset();
      test_add();
      test_base_random();
      test_directed_iter();
      test_random_mix();
      test_back_to_back();
      test_stall();
      test_abort(1'b0);
      test_abort(1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
